uart_rx_fifo: RTL and testbench

Receive buffer directly downstream of the UART receiver. It consumes the receiver's held-word handshake: it captures each completed character or break event together with its error flags, and acknowledges it with a one-cycle receiveReq pulse. Captured entries go into a first-word-fall-through FIFO. The block provides host-side status, a programmable trigger-level interrupt and a silence-based character timeout.

---
 rtl/uart_rx_fifo.sv | 86 ++++++++
 tb/tb_uart_rx_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures held receiver words/breaks into a first-word-fall-through FIFO
// with host status, trigger-level interrupt and silence-based character timeout.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8:0]            rxData,
    input  logic                  rxDataReceived,
    input  logic                  rxParityError,
    input  logic                  rxOverflow,
    input  logic                  rxBreak,
    input  logic                  rxSilence,
    output logic                  receiveReq,
    input  logic                  readEn,
    output logic [10:0]           readData,
    input  logic                  flush,
    input  logic                  clearOverrun,
    input  logic [DEPTH_LOG2:0]   triggerLevel,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overrun,
    output logic                  errorInFifo,
    output logic                  timeout,
    output logic                  irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;

    logic [10:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   err_cnt;
    logic                  capture, push, pop, lost, entry_err, head_err;
    logic [10:0]           entry;

    // receiveReq blocks a second capture while the receiver is still dropping its flags
    assign capture   = (rxDataReceived || rxBreak) && !receiveReq;
    assign entry     = {rxBreak, rxDataReceived & rxParityError, rxDataReceived ? rxData : 9'd0};
    assign entry_err = entry[10] | entry[9];
    assign head_err  = readData[10] | readData[9];
    assign pop       = readEn && !empty && !flush;
    assign push      = capture && !flush && (!full || pop);
    assign lost      = capture && !flush && full && !pop;

    assign readData    = mem[rd_ptr];
    assign empty       = count == '0;
    assign full        = count == CW'(DEPTH);
    assign errorInFifo = err_cnt != '0;
    assign timeout     = rxSilence && !empty;
    assign irq         = (triggerLevel != '0 && count >= triggerLevel) || timeout;

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_cnt    <= '0;
            receiveReq <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            receiveReq <= capture;
            if (capture && (rxOverflow || lost))
                overrun <= 1'b1;
            else if (clearOverrun)
                overrun <= 1'b0;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                err_cnt <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count   <= count + CW'(push) - CW'(pop);
                err_cnt <= err_cnt + CW'(push && entry_err) - CW'(pop && head_err);
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;
    logic        clk = 0, rst = 1;
    logic [8:0]  rxData = 0;
    logic        rxDataReceived = 0, rxParityError = 0, rxOverflow = 0, rxBreak = 0, rxSilence = 0;
    logic        readEn = 0, flush = 0, clearOverrun = 0;
    logic [4:0]  triggerLevel = 0;
    logic        receiveReq, empty, full, overrun, errorInFifo, timeout, irq;
    logic [10:0] readData;
    logic [4:0]  count;

    int errors = 0, checks = 0;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .rxData(rxData), .rxDataReceived(rxDataReceived),
        .rxParityError(rxParityError), .rxOverflow(rxOverflow), .rxBreak(rxBreak),
        .rxSilence(rxSilence), .receiveReq(receiveReq), .readEn(readEn), .readData(readData),
        .flush(flush), .clearOverrun(clearOverrun), .triggerLevel(triggerLevel), .count(count),
        .empty(empty), .full(full), .overrun(overrun), .errorInFifo(errorInFifo),
        .timeout(timeout), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [10:0] q[$];
    bit m_ovr, m_rreq;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovr = 0;
        m_rreq = 0;
    endtask

    task automatic model_edge();
        bit cap, lost, do_pop, was_full;
        logic [10:0] e;
        cap = (rxDataReceived || rxBreak) && !m_rreq;
        e = {rxBreak, rxDataReceived & rxParityError, rxDataReceived ? rxData : 9'd0};
        was_full = q.size() == 16;
        do_pop = readEn && q.size() != 0 && !flush;
        lost = 0;
        if (flush) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (cap) begin
                if (!was_full || do_pop) q.push_back(e);
                else lost = 1;
            end
        end
        if (cap && (rxOverflow || lost)) m_ovr = 1;
        else if (clearOverrun) m_ovr = 0;
        m_rreq = cap;
    endtask

    task automatic check_model();
        int n_err;
        bit m_tmo;
        n_err = 0;
        foreach (q[i]) if (q[i][10] || q[i][9]) n_err++;
        m_tmo = rxSilence && q.size() != 0;
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == 16));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("receiveReq", 32'(receiveReq), 32'(m_rreq));
        chk("errorInFifo", 32'(errorInFifo), 32'(n_err != 0));
        chk("timeout", 32'(timeout), 32'(m_tmo));
        chk("irq", 32'(irq), 32'((triggerLevel != 0 && q.size() >= int'(triggerLevel)) || m_tmo));
        if (q.size() != 0) chk("readData", 32'(readData), 32'(q[0]));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic put(logic [8:0] d, bit ovf);
        rxData = d;
        rxDataReceived = 1;
        rxOverflow = ovf;
        step();
        rxDataReceived = 0;
        rxOverflow = 0;
    endtask

    task automatic push(logic [8:0] d);
        put(d, 0);
        step();
    endtask

    task automatic pop();
        readEn = 1;
        step();
        readEn = 0;
    endtask

    typedef struct {
        logic       dr, brk, par, rd;
        logic [8:0] data;
        int         exp_count;
        logic       exp_rreq, exp_err;
        logic [10:0] exp_head;
    } vec_t;

    vec_t vecs[16];
    logic [10:0] last;

    initial begin
        vecs[0]  = '{1, 0, 0, 0, 9'h041, 1, 1, 0, 11'h041};
        vecs[1]  = '{1, 0, 0, 0, 9'h041, 1, 0, 0, 11'h041};
        vecs[2]  = '{0, 0, 0, 1, 9'h000, 0, 0, 0, 11'h000};
        vecs[3]  = '{0, 1, 0, 0, 9'h000, 1, 1, 1, 11'h400};
        vecs[4]  = '{0, 1, 0, 0, 9'h000, 1, 0, 1, 11'h400};
        vecs[5]  = '{1, 0, 1, 0, 9'h1FF, 2, 1, 1, 11'h400};
        vecs[6]  = '{0, 0, 0, 0, 9'h000, 2, 0, 1, 11'h400};
        vecs[7]  = '{0, 0, 0, 1, 9'h000, 1, 0, 1, 11'h3FF};
        vecs[8]  = '{0, 0, 0, 1, 9'h000, 0, 0, 0, 11'h000};
        vecs[9]  = '{0, 0, 0, 1, 9'h000, 0, 0, 0, 11'h000};
        vecs[10] = '{1, 1, 1, 0, 9'h0AB, 1, 1, 1, 11'h6AB};
        vecs[11] = '{0, 0, 0, 0, 9'h000, 1, 0, 1, 11'h6AB};
        vecs[12] = '{0, 0, 0, 1, 9'h000, 0, 0, 0, 11'h000};
        vecs[13] = '{0, 1, 1, 0, 9'h1FF, 1, 1, 1, 11'h400};
        vecs[14] = '{0, 0, 0, 0, 9'h000, 1, 0, 1, 11'h400};
        vecs[15] = '{0, 0, 0, 1, 9'h000, 0, 0, 0, 11'h000};

        model_reset();
        #12;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_err", 32'(errorInFifo), 0);
        check_model();
        @(posedge clk);
        #1 rst = 0;

        foreach (vecs[i]) begin
            rxDataReceived = vecs[i].dr;
            rxBreak = vecs[i].brk;
            rxParityError = vecs[i].par;
            readEn = vecs[i].rd;
            rxData = vecs[i].data;
            step();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_rreq", i), 32'(receiveReq), 32'(vecs[i].exp_rreq));
            chk($sformatf("vec%0d_err", i), 32'(errorInFifo), 32'(vecs[i].exp_err));
            if (vecs[i].exp_count != 0)
                chk($sformatf("vec%0d_head", i), 32'(readData), 32'(vecs[i].exp_head));
        end
        {rxDataReceived, rxBreak, rxParityError, readEn} = 0;
        step();

        for (int i = 0; i < 16; i++) push(9'(i));
        put(9'h0AA, 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_ovr", 32'(overrun), 1);
        chk("fill_rreq", 32'(receiveReq), 1);
        chk("fill_head", 32'(readData), 0);
        clearOverrun = 1;
        step();
        clearOverrun = 0;
        chk("clr_ovr", 32'(overrun), 0);

        readEn = 1;
        put(9'h155, 0);
        readEn = 0;
        chk("fullrw_count", 32'(count), 16);
        chk("fullrw_ovr", 32'(overrun), 0);
        step();
        for (int i = 0; i < 16; i++) begin
            last = readData;
            pop();
        end
        chk("fullrw_last", 32'(last), 11'h155);
        chk("fullrw_empty", 32'(empty), 1);

        triggerLevel = 4;
        for (int i = 0; i < 3; i++) push(9'(i + 8'h20));
        chk("trig3_irq", 32'(irq), 0);
        push(9'h023);
        chk("trig4_irq", 32'(irq), 1);
        pop();
        chk("trigpop_irq", 32'(irq), 0);
        pop();
        pop();
        rxSilence = 1;
        #1;
        chk("silence_timeout", 32'(timeout), 1);
        chk("silence_irq", 32'(irq), 1);
        rxSilence = 0;
        triggerLevel = 0;
        for (int i = 0; i < 15; i++) push(9'(i + 8'h30));
        chk("trig0_count", 32'(count), 16);
        chk("trig0_irq", 32'(irq), 0);
        triggerLevel = 17;
        #1 chk("trig17_irq", 32'(irq), 0);
        triggerLevel = 16;
        #1 chk("trig16_irq", 32'(irq), 1);
        triggerLevel = 0;
        flush = 1;
        step();
        flush = 0;

        for (int i = 0; i < 4; i++) push(9'(i + 8'h50));
        put(9'h054, 1);
        step();
        chk("preflush_ovr", 32'(overrun), 1);
        flush = 1;
        put(9'h077, 0);
        flush = 0;
        chk("flush_count", 32'(count), 0);
        chk("flush_ovr", 32'(overrun), 1);
        chk("flush_rreq", 32'(receiveReq), 1);
        step();

        for (int i = 0; i < 4; i++) push(9'(i + 8'h60));
        put(9'h064, 1);
        chk("prerst_rreq", 32'(receiveReq), 1);
        #2 rst = 1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_rreq", 32'(receiveReq), 0);
        chk("arst_ovr", 32'(overrun), 0);
        chk("arst_empty", 32'(empty), 1);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        step();

        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) triggerLevel = 5'($urandom_range(0, 20));
            rxData = 9'($urandom);
            rxDataReceived = $urandom_range(0, 2) == 0;
            rxBreak = $urandom_range(0, 7) == 0;
            rxParityError = $urandom_range(0, 3) == 0;
            rxOverflow = $urandom_range(0, 15) == 0;
            rxSilence = $urandom_range(0, 3) == 0;
            readEn = $urandom_range(0, 2) == 0;
            flush = $urandom_range(0, 63) == 0;
            clearOverrun = $urandom_range(0, 15) == 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
